// File: rtl/ascon_pack.sv
// Shared types and helpers for the ASCON permutation engine: state layout,
// FSM encoding, round-count limits and the per-round constant.
package ascon_pack;

  localparam int unsigned NB_ROUNDS_MAX = 12;
  localparam int unsigned ROUNDS_A      = 12;
  localparam int unsigned ROUNDS_B      = 6;
  localparam int unsigned ROUNDS_B8     = 8;

  // s0 occupies the most significant 64 bits of the packed 320-bit state
  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
  } type_state;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_state_e;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Anything other than 6 or 8 runs the full-strength permutation
  function automatic logic [3:0] sanitise_rounds(input logic [3:0] nb);
    logic [3:0] n;
    case (nb)
      4'(ROUNDS_B):  n = 4'(ROUNDS_B);
      4'(ROUNDS_B8): n = 4'(ROUNDS_B8);
      default:       n = 4'(ROUNDS_A);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, 5-bit substitution layer
// (bitsliced) and the per-word linear diffusion layer.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  cur,
  input  logic [3:0] idx,
  output type_state  nxt
);

  logic [63:0] x0_s, x1_s, x2_s, x3_s, x4_s;
  logic [63:0] t0_s, t1_s, t2_s, t3_s, t4_s;

  // Constant addition, bitsliced S-box and linear layer for round idx
  always_comb begin
    x0_s = cur.s0;
    x1_s = cur.s1;
    x2_s = cur.s2 ^ {56'd0, round_const(idx)};
    x3_s = cur.s3;
    x4_s = cur.s4;

    x0_s = x0_s ^ x4_s;
    x4_s = x4_s ^ x3_s;
    x2_s = x2_s ^ x1_s;
    t0_s = ~x0_s & x1_s;
    t1_s = ~x1_s & x2_s;
    t2_s = ~x2_s & x3_s;
    t3_s = ~x3_s & x4_s;
    t4_s = ~x4_s & x0_s;
    x0_s = x0_s ^ t1_s;
    x1_s = x1_s ^ t2_s;
    x2_s = x2_s ^ t3_s;
    x3_s = x3_s ^ t4_s;
    x4_s = x4_s ^ t0_s;
    x1_s = x1_s ^ x0_s;
    x0_s = x0_s ^ x4_s;
    x3_s = x3_s ^ x2_s;
    x2_s = ~x2_s;

    nxt.s0 = x0_s ^ rotr(x0_s, 19) ^ rotr(x0_s, 28);
    nxt.s1 = x1_s ^ rotr(x1_s, 61) ^ rotr(x1_s, 39);
    nxt.s2 = x2_s ^ rotr(x2_s, 1)  ^ rotr(x2_s, 6);
    nxt.s3 = x3_s ^ rotr(x3_s, 10) ^ rotr(x3_s, 17);
    nxt.s4 = x4_s ^ rotr(x4_s, 7)  ^ rotr(x4_s, 41);
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequenced ASCON p^a/p^b engine: start/done handshake, UNROLL rounds per
// clock, optional data injection into S0 at start and key injection at the end.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [3:0]   nb_rounds_i,
  input  type_state    state_i,
  input  logic [63:0]  data_i,
  input  logic [127:0] key_i,
  input  logic         xor_begin_i,
  input  logic         xor_end_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   round_o,
  output type_state    state_o
);

  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1 or 2");
  end

  localparam logic [3:0] STEP       = 4'(UNROLL);
  localparam logic [3:0] LAST_START = 4'(NB_ROUNDS_MAX - UNROLL);

  fsm_state_e   fsm_r, fsm_s;
  type_state    state_r;
  logic [3:0]   round_r;
  logic         xor_end_r;
  logic [127:0] key_r;
  logic         busy_r, done_r;

  logic         load_s, step_s, finish_s, last_group_s;
  type_state    load_state_s, result_s;
  type_state    chain_s [UNROLL+1];

  assign chain_s[0] = state_r;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round u_round (
      .cur (chain_s[g]),
      .idx (round_r + 4'(g)),
      .nxt (chain_s[g+1])
    );
  end

  // The group ending on index 11 is the last one regardless of n
  assign last_group_s = (round_r == LAST_START);

  // Next-state decode and the load/step/finish strobes
  always_comb begin
    fsm_s    = fsm_r;
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (fsm_r)
      FSM_IDLE: begin
        if (start_i) begin
          fsm_s  = FSM_RUN;
          load_s = 1'b1;
        end else begin
          fsm_s  = FSM_IDLE;
        end
      end
      FSM_RUN: begin
        if (last_group_s) begin
          fsm_s    = FSM_DONE;
          finish_s = 1'b1;
        end else begin
          step_s   = 1'b1;
        end
      end
      FSM_DONE: fsm_s = FSM_IDLE;
      default:  fsm_s = FSM_IDLE;
    endcase
  end

  // Begin/end XOR injection muxes around the round chain
  always_comb begin
    load_state_s = state_i;
    if (xor_begin_i) begin
      load_state_s.s0 = state_i.s0 ^ data_i;
    end else begin
      load_state_s.s0 = state_i.s0;
    end
    result_s = chain_s[UNROLL];
    if (xor_end_r) begin
      result_s.s3 = chain_s[UNROLL].s3 ^ key_r[127:64];
      result_s.s4 = chain_s[UNROLL].s4 ^ key_r[63:0];
    end else begin
      result_s = chain_s[UNROLL];
    end
  end

  // FSM, round counter, latched mode bits and state register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_r     <= FSM_IDLE;
      state_r   <= '0;
      round_r   <= 4'd0;
      xor_end_r <= 1'b0;
      key_r     <= 128'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      fsm_r  <= fsm_s;
      busy_r <= (fsm_s != FSM_IDLE);
      done_r <= (fsm_s == FSM_DONE);
      if (load_s) begin
        state_r   <= load_state_s;
        round_r   <= 4'(NB_ROUNDS_MAX) - sanitise_rounds(nb_rounds_i);
        xor_end_r <= xor_end_i;
        key_r     <= key_i;
      end else if (step_s) begin
        state_r <= chain_s[UNROLL];
        round_r <= round_r + STEP;
      end else if (finish_s) begin
        state_r <= result_s;
      end
    end
  end

  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign round_o = round_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Randomized bench for ascon_perm_engine: UNROLL=1 and UNROLL=2 instances share
// stimulus and are checked every cycle against a column-wise S-box table model.
module tb_ascon_perm_engine;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic [3:0]   nb_rounds_i = 4'd0;
  logic [319:0] state_i = 320'd0;
  logic [63:0]  data_i = 64'd0;
  logic [127:0] key_i = 128'd0;
  logic         xor_begin_i = 1'b0;
  logic         xor_end_i = 1'b0;

  logic [1:0]         dut_busy, dut_done;
  logic [1:0][3:0]    dut_round;
  logic [1:0][319:0]  dut_state;

  int total = 0;
  int bad = 0;

  always #5 clock_i = ~clock_i;

  ascon_perm_engine #(.UNROLL(1)) u_dut1 (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .nb_rounds_i(nb_rounds_i),
    .state_i(state_i), .data_i(data_i), .key_i(key_i), .xor_begin_i(xor_begin_i),
    .xor_end_i(xor_end_i), .busy_o(dut_busy[0]), .done_o(dut_done[0]),
    .round_o(dut_round[0]), .state_o(dut_state[0])
  );

  ascon_perm_engine #(.UNROLL(2)) u_dut2 (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .nb_rounds_i(nb_rounds_i),
    .state_i(state_i), .data_i(data_i), .key_i(key_i), .xor_begin_i(xor_begin_i),
    .xor_end_i(xor_end_i), .busy_o(dut_busy[1]), .done_o(dut_done[1]),
    .round_o(dut_round[1]), .state_o(dut_state[1])
  );

  // ASCON 5-bit S-box, input column {x0,x1,x2,x3,x4} with x0 as MSB
  int sbox_tab [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                        30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] brot(input logic [63:0] x, input int n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] st, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [319:0] res;
    int ra [5];
    int rb [5];
    int col;
    int o;
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) x[i] = st[319 - 64*i -: 64];
    x[2] = x[2] ^ 64'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      col = 0;
      for (int i = 0; i < 5; i++) col = col * 2 + int'(x[i][b]);
      o = sbox_tab[col];
      for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
    end
    for (int i = 0; i < 5; i++) res[319 - 64*i -: 64] = y[i] ^ brot(y[i], ra[i]) ^ brot(y[i], rb[i]);
    return res;
  endfunction

  function automatic int model_n(input logic [3:0] nb);
    if (nb == 4'd6) return 6;
    if (nb == 4'd8) return 8;
    return 12;
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] st, input logic [3:0] nb,
      input logic xb, input logic xe, input logic [63:0] d, input logic [127:0] k);
    logic [319:0] s;
    s = st;
    if (xb) s[319:256] = s[319:256] ^ d;
    for (int r = 12 - model_n(nb); r < 12; r++) s = model_round(s, r);
    if (xe) s[127:0] = s[127:0] ^ k;
    return s;
  endfunction

  // Model: per instance, cycles left until idle; RUN while >1, DONE at 1
  int           rem [2] = '{0, 0};
  int           m_round [2] = '{0, 0};
  bit           m_done [2] = '{1'b0, 1'b0};
  bit           m_valid [2] = '{1'b0, 1'b0};
  logic [319:0] m_state [2];
  logic [319:0] m_result [2];
  bit           live = 1'b0;

  initial begin
    forever begin
      @(posedge clock_i);
      for (int i = 0; i < 2; i++) begin
        if (reset_i) begin
          rem[i] = 0; m_round[i] = 0; m_done[i] = 1'b0;
          m_state[i] = 320'd0; m_valid[i] = 1'b1; live = 1'b1;
        end else if (live) begin
          if (rem[i] == 0) begin
            m_done[i] = 1'b0;
            if (start_i) begin
              m_result[i] = model_perm(state_i, nb_rounds_i, xor_begin_i, xor_end_i, data_i, key_i);
              rem[i] = model_n(nb_rounds_i) / (i + 1) + 1;
              m_round[i] = 12 - model_n(nb_rounds_i);
              m_valid[i] = 1'b0;
            end
          end else begin
            rem[i] = rem[i] - 1;
            if (rem[i] == 1) begin
              m_done[i] = 1'b1; m_state[i] = m_result[i]; m_valid[i] = 1'b1;
            end else if (rem[i] == 0) begin
              m_done[i] = 1'b0;
            end else begin
              m_round[i] = m_round[i] + i + 1;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model
  initial begin
    forever begin
      @(negedge clock_i);
      if (live) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("busy_u%0d", i + 1), 320'(dut_busy[i]), 320'(rem[i] > 0));
          chk($sformatf("done_u%0d", i + 1), 320'(dut_done[i]), 320'(m_done[i]));
          chk($sformatf("round_u%0d", i + 1), 320'(dut_round[i]), 320'(m_round[i]));
          if (m_valid[i]) chk($sformatf("state_u%0d", i + 1), dut_state[i], m_state[i]);
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (dut_busy != 2'b00 && k < 50) begin
      @(negedge clock_i);
      k++;
    end
    chk("idle_wait", 320'(dut_busy), 320'd0);
  endtask

  task automatic run_one(input logic [3:0] nb, input logic xb, input logic xe,
      input logic [319:0] st, input logic [63:0] d, input logic [127:0] k,
      input int l1_exp, input int l2_exp);
    int l1, l2, c;
    wait_idle();
    nb_rounds_i = nb; xor_begin_i = xb; xor_end_i = xe;
    state_i = st; data_i = d; key_i = k; start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    c = 1; l1 = 0; l2 = 0;
    while (c < 40 && (l1 == 0 || l2 == 0)) begin
      if (dut_done[0] && l1 == 0) l1 = c;
      if (dut_done[1] && l2 == 0) l2 = c;
      @(negedge clock_i);
      c++;
    end
    chk($sformatf("latency_u1_nb%0d", nb), 320'(l1), 320'(l1_exp));
    chk($sformatf("latency_u2_nb%0d", nb), 320'(l2), 320'(l2_exp));
  endtask

  function automatic logic [319:0] rnd320();
    return {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [319:0] pin;
    int prev [2];
    int npulse [2];
    int k;
    logic [3:0] nb_sel;

    // Hand-derived single round of the all-zero state at index 0
    pin = model_round(320'd0, 0);
    chk("model_pin_s0", 320'(pin[319:256]), 320'(64'h001E0F00000000F0));
    chk("model_pin_s1", 320'(pin[255:192]), 320'(64'h00000001E0000770));
    chk("model_pin_s2", 320'(pin[191:128]), 320'(64'h3FFFFFFFFFFFFF74));
    chk("model_pin_s3", 320'(pin[127:64]),  320'(64'h3C780000000000F0));
    chk("model_pin_s4", 320'(pin[63:0]),    320'd0);

    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    chk("reset_busy", 320'(dut_busy), 320'd0);
    chk("reset_state_u1", dut_state[0], 320'd0);

    run_one(4'd12, 1'b0, 1'b0,
            {64'h00001000808c0001, 64'h6cb10ad9ca912f80, 64'h691aed630e81901f,
             64'h0c4c36a20853217c, 64'h46487b3e06d9d7a8},
            64'd0, 128'd0, 13, 7);
    run_one(4'd6, 1'b1, 1'b0, rnd320(), 64'h8000000000000000, 128'd0, 7, 4);
    run_one(4'd12, 1'b0, 1'b1, rnd320(), 64'd0, 128'h000102030405060708090a0b0c0d0e0f, 13, 7);
    run_one(4'd5, 1'b1, 1'b1, rnd320(), 64'h0123456789abcdef, 128'hffeeddccbbaa99887766554433221100, 13, 7);
    run_one(4'd8, 1'b0, 1'b0, rnd320(), 64'd0, 128'd0, 9, 5);

    // start_i held high: one permutation per IDLE visit
    wait_idle();
    nb_rounds_i = 4'd12; xor_begin_i = 1'b0; xor_end_i = 1'b0; state_i = rnd320(); start_i = 1'b1;
    prev = '{-1, -1};
    npulse = '{0, 0};
    for (int c = 0; c < 70; c++) begin
      @(negedge clock_i);
      for (int i = 0; i < 2; i++) begin
        if (dut_done[i]) begin
          if (prev[i] >= 0) chk($sformatf("held_gap_u%0d", i + 1), 320'(c - prev[i]), 320'(i == 0 ? 14 : 8));
          prev[i] = c;
          npulse[i]++;
        end
      end
    end
    start_i = 1'b0;
    chk("held_pulses_u1", 320'(npulse[0] >= 4), 320'd1);
    chk("held_pulses_u2", 320'(npulse[1] >= 8), 320'd1);

    // Abort a p^12 at round 5 with reset
    wait_idle();
    nb_rounds_i = 4'd12; state_i = rnd320(); start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    k = 0;
    while (dut_round[0] != 4'd5 && k < 30) begin
      @(negedge clock_i);
      k++;
    end
    chk("reach_round5", 320'(dut_round[0]), 320'd5);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("abort_busy", 320'(dut_busy), 320'd0);
    chk("abort_done", 320'(dut_done), 320'd0);
    chk("abort_state_u1", dut_state[0], 320'd0);
    chk("abort_state_u2", dut_state[1], 320'd0);
    run_one(4'd12, 1'b1, 1'b1, rnd320(), {$urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 13, 7);

    // Random traffic, occasional resets, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock_i);
      reset_i = ($urandom_range(0, 299) == 0);
      start_i = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: nb_sel = 4'd6;
        1: nb_sel = 4'd8;
        2: nb_sel = 4'd12;
        default: nb_sel = 4'($urandom_range(0, 15));
      endcase
      nb_rounds_i = nb_sel;
      state_i = rnd320();
      data_i = {$urandom, $urandom};
      key_i = {$urandom, $urandom, $urandom, $urandom};
      xor_begin_i = 1'($urandom_range(0, 1));
      xor_end_i = 1'($urandom_range(0, 1));
    end
    reset_i = 1'b0;
    start_i = 1'b0;
    repeat (20) @(negedge clock_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
